calculation_unit_fraction_adder_arbiter: RTL and testbench

CALCULATION_UNIT_FRACTION_ADDER_ARBITER -- requirements
Module: calculation_unit_fraction_adder_arbiter

---
 rtl/calculation_unit_fraction_adder_arbiter.sv | 132 +++++++++++++
 tb/tb_calculation_unit_fraction_adder_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/calculation_unit_fraction_adder_arbiter.sv
// calculation_unit_fraction_adder_arbiter
//
// Two-requester round-robin arbiter in front of a fraction adder with a
// single result register. Each requester presents a 1.23 fraction a and a
// 2.47 fraction b. The winning requester's sum is {0, a, 24'd0} + b,
// truncated to 49 bits (2.47), and is registered together with the
// requester id and its opaque tag.
//
// Ports
//   clk             : clock, rising edge
//   reset           : asynchronous active-high reset
//   req_valid[1:0]  : per-requester operand valid
//   req_ready[1:0]  : per-requester accept (one-hot or zero)
//   reqN_fraction_a : 24-bit operand a, 1 integer bit
//   reqN_fraction_b : 49-bit operand b, 2 integer bits
//   reqN_tag        : TAG_WIDTH-bit opaque tag
//   out_valid       : result register holds data
//   out_ready       : downstream accept
//   out_sum         : registered 49-bit sum
//   out_id          : winning requester
//   out_tag         : winning requester's tag
//
// Configuration
//   CALC_UNIT_FRACTION_ADDER_ARBITER_FIXED_PRIORITY_EN
//     defined   : requester 0 always wins a tie, no priority flop
//     undefined : round-robin, the loser of each transfer is favoured next
//
// State | meaning
// ------+---------------------------------------------
// EMPTY | result register holds nothing (out_valid=0)
// FULL  | result register holds a result (out_valid=1)

module calculation_unit_fraction_adder_arbiter #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [23:0]          req0_fraction_a,
    input  logic [48:0]          req0_fraction_b,
    input  logic [TAG_WIDTH-1:0] req0_tag,
    input  logic [23:0]          req1_fraction_a,
    input  logic [48:0]          req1_fraction_b,
    input  logic [TAG_WIDTH-1:0] req1_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [48:0]          out_sum,
    output logic                 out_id,
    output logic [TAG_WIDTH-1:0] out_tag
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        free;
    logic        prio;
    logic [1:0]  gnt;
    logic        xfer;
    logic        win;
    logic [48:0] sum0;
    logic [48:0] sum1;

    // A pop and a load may share a cycle, so the register is free whenever
    // downstream is taking the current result.
    assign free = (state_q == ST_EMPTY) || out_ready;

`ifdef CALC_UNIT_FRACTION_ADDER_ARBITER_FIXED_PRIORITY_EN
    assign prio = 1'b0;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (xfer) begin
            prio <= ~win;
        end
    end
`endif

    // Grant depends only on handshake state and prio, never on operand data.
    // Reset gates the grant so nothing is accepted while it is held.
    always_comb begin
        gnt     = 2'b00;
        state_d = state_q;
        if (!reset && free) begin
            if (req_valid == 2'b11) begin
                gnt = prio ? 2'b10 : 2'b01;
            end else begin
                gnt = req_valid;
            end
        end
        if (|gnt) begin
            state_d = ST_FULL;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    assign req_ready = gnt;
    assign xfer      = |gnt;
    assign win       = gnt[1];

    assign sum0 = {1'b0, req0_fraction_a, 24'd0} + req0_fraction_b;
    assign sum1 = {1'b0, req1_fraction_a, 24'd0} + req1_fraction_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_sum <= '0;
            out_id  <= 1'b0;
            out_tag <= '0;
        end else if (xfer) begin
            out_sum <= win ? sum1 : sum0;
            out_id  <= win;
            out_tag <= win ? req1_tag : req0_tag;
        end
    end

    assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_calculation_unit_fraction_adder_arbiter.sv
module tb_calculation_unit_fraction_adder_arbiter;

    logic        clk;
    logic        clk_run;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [23:0] req0_fraction_a;
    logic [48:0] req0_fraction_b;
    logic [3:0]  req0_tag;
    logic [23:0] req1_fraction_a;
    logic [48:0] req1_fraction_b;
    logic [3:0]  req1_tag;
    logic        out_valid;
    logic        out_ready;
    logic [48:0] out_sum;
    logic        out_id;
    logic [3:0]  out_tag;

    int n_chk;
    int n_bad;

    calculation_unit_fraction_adder_arbiter #(.TAG_WIDTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req0_fraction_a (req0_fraction_a),
        .req0_fraction_b (req0_fraction_b),
        .req0_tag        (req0_tag),
        .req1_fraction_a (req1_fraction_a),
        .req1_fraction_b (req1_fraction_b),
        .req1_tag        (req1_tag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sum         (out_sum),
        .out_id          (out_id),
        .out_tag         (out_tag)
    );

    // Stoppable clock: when clk_run drops the clock parks low.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
            else         clk = 1'b0;
        end
    end

    typedef struct {
        logic [1:0]  v;
        logic [23:0] a0;
        logic [48:0] b0;
        logic [3:0]  t0;
        logic [23:0] a1;
        logic [48:0] b1;
        logic [3:0]  t1;
        logic        ordy;
        logic [1:0]  erdy;
        logic        evld;
        logic [48:0] esum;
        logic        eid;
        logic [3:0]  etag;
    } vec_t;

    vec_t tbl [10];

`ifdef CALC_UNIT_FRACTION_ADDER_ARBITER_FIXED_PRIORITY_EN
    localparam logic [1:0]  S4_RDY = 2'b01;
    localparam logic [48:0] S4_SUM = 49'h0000001000001;
    localparam logic        S4_ID  = 1'b0;
    localparam logic [3:0]  S4_TAG = 4'h1;
    localparam logic [1:0]  RR_ODD = 2'b01;
    localparam logic        ID_ODD = 1'b0;
`else
    localparam logic [1:0]  S4_RDY = 2'b10;
    localparam logic [48:0] S4_SUM = 49'h0000002000002;
    localparam logic        S4_ID  = 1'b1;
    localparam logic [3:0]  S4_TAG = 4'h2;
    localparam logic [1:0]  RR_ODD = 2'b10;
    localparam logic        ID_ODD = 1'b1;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [23:0] a0, input logic [48:0] b0,
                         input logic [3:0] t0, input logic [23:0] a1, input logic [48:0] b1,
                         input logic [3:0] t1, input logic ordy);
        req_valid       = v;
        req0_fraction_a = a0;
        req0_fraction_b = b0;
        req0_tag        = t0;
        req1_fraction_a = a1;
        req1_fraction_b = b1;
        req1_tag        = t1;
        out_ready       = ordy;
    endtask

    initial begin
        n_chk   = 0;
        n_bad   = 0;
        clk_run = 1'b1;
        reset   = 1'b1;
        drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0);

        //        v      a0          b0                 t0    a1          b1                 t1    ordy  erdy    evld  esum               eid   etag
        tbl[0] = '{2'b01, 24'h800000, 49'h0,             4'h3, 24'h0,      49'h0,             4'h0, 1'b1, 2'b01,  1'b1, 49'h0800000000000, 1'b0, 4'h3};
        tbl[1] = '{2'b10, 24'h0,      49'h0,             4'h0, 24'hFFFFFF, 49'h1FFFFFFFFFFFF, 4'h5, 1'b1, 2'b10,  1'b1, 49'h0FFFFFEFFFFFF, 1'b1, 4'h5};
        tbl[2] = '{2'b11, 24'h000001, 49'h1,             4'h1, 24'h000002, 49'h2,             4'h2, 1'b1, 2'b01,  1'b1, 49'h0000001000001, 1'b0, 4'h1};
        tbl[3] = '{2'b11, 24'h000001, 49'h1,             4'h1, 24'h000002, 49'h2,             4'h2, 1'b1, S4_RDY, 1'b1, S4_SUM,            S4_ID, S4_TAG};
        tbl[4] = '{2'b00, 24'h0,      49'h0,             4'h0, 24'h0,      49'h0,             4'h0, 1'b1, 2'b00,  1'b0, S4_SUM,            S4_ID, S4_TAG};
        tbl[5] = '{2'b00, 24'h0,      49'h0,             4'h0, 24'h0,      49'h0,             4'h0, 1'b0, 2'b00,  1'b0, S4_SUM,            S4_ID, S4_TAG};
        tbl[6] = '{2'b01, 24'h400000, 49'h0800000000000, 4'h7, 24'h0,      49'h0,             4'h0, 1'b0, 2'b01,  1'b1, 49'h0C00000000000, 1'b0, 4'h7};
        tbl[7] = '{2'b01, 24'h123456, 49'h1,             4'h8, 24'h0,      49'h0,             4'h0, 1'b0, 2'b00,  1'b1, 49'h0C00000000000, 1'b0, 4'h7};
        tbl[8] = '{2'b01, 24'h123456, 49'h1,             4'h8, 24'h0,      49'h0,             4'h0, 1'b1, 2'b01,  1'b1, 49'h0123456000001, 1'b0, 4'h8};
        tbl[9] = '{2'b00, 24'h0,      49'h0,             4'h0, 24'h0,      49'h0,             4'h0, 1'b1, 2'b00,  1'b0, 49'h0123456000001, 1'b0, 4'h8};

        // Reset state
        #1;
        chk("rst_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_sum",   64'(out_sum),   64'(49'h0));
        chk("rst_ready", 64'(req_ready), 64'(2'b00));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].t0,
                  tbl[i].a1, tbl[i].b1, tbl[i].t1, tbl[i].ordy);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tbl[i].erdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].evld));
            chk($sformatf("v%0d_sum", i),   64'(out_sum),   64'(tbl[i].esum));
            chk($sformatf("v%0d_id", i),    64'(out_id),    64'(tbl[i].eid));
            chk($sformatf("v%0d_tag", i),   64'(out_tag),   64'(tbl[i].etag));
        end

        // Backpressure: hold a result for 5 cycles while req0 keeps asking
        drive(2'b01, 24'h000010, 49'h0, 4'h9, '0, '0, '0, 1'b0);
        #1;
        chk("bp_load_ready", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1;
        chk("bp_load_sum", 64'(out_sum), 64'(49'h0000010000000));
        drive(2'b01, 24'h000020, 49'h0, 4'hA, '0, '0, '0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d_ready", k), 64'(req_ready), 64'(2'b00));
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", k), 64'(out_valid), 64'(1'b1));
            chk($sformatf("bp%0d_sum", k),   64'(out_sum),   64'(49'h0000010000000));
            chk($sformatf("bp%0d_tag", k),   64'(out_tag),   64'(4'h9));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_pop_ready", 64'(req_ready), 64'(2'b01));
        @(posedge clk);
        #1;
        chk("bp_pop_valid", 64'(out_valid), 64'(1'b1));
        chk("bp_pop_sum",   64'(out_sum),   64'(49'h0000020000000));
        chk("bp_pop_tag",   64'(out_tag),   64'(4'hA));

        // Asynchronous reset with the clock stopped and a result held
        clk_run = 1'b0;
        #12;
        drive(2'b11, 24'h000001, 49'h1, 4'h1, 24'h000002, 49'h2, 4'h2, 1'b1);
        reset = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'(1'b0));
        chk("ar_sum",   64'(out_sum),   64'(49'h0));
        chk("ar_tag",   64'(out_tag),   64'(4'h0));
        chk("ar_ready", 64'(req_ready), 64'(2'b00));
        #5;
        reset = 1'b0;
        #1;
        chk("ar_tie_ready", 64'(req_ready), 64'(2'b01));
        clk_run = 1'b1;

        // Both requesters streaming with out_ready high
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                #1;
                chk($sformatf("st%0d_ready", k), 64'(req_ready), 64'((k % 2 == 1) ? RR_ODD : 2'b01));
            end
            @(posedge clk);
            #1;
            chk($sformatf("st%0d_valid", k), 64'(out_valid), 64'(1'b1));
            chk($sformatf("st%0d_id", k),    64'(out_id),    64'((k % 2 == 1) ? ID_ODD : 1'b0));
        end

        drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        chk("drain_valid", 64'(out_valid), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
